// File: rtl/display_pkg.sv
// Shared definitions for the display controller: SPI command encodings,
// decoder state type and pixel width helper.
package display_pkg;

  localparam logic [3:0] CMD_ROW_PREFIX = 4'hF;
  localparam logic [7:0] CMD_LOAD       = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ROW,
    ST_LOAD,
    ST_DISCARD
  } dec_state_t;

  function automatic int pixel_width(input int bitwidth);
    return 3 * bitwidth;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizers for the SPI pins plus sclk rising-edge detection
// in the system clock domain.
module spi_input_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss,
  input  logic mosi,
  output logic sclk_rise,
  output logic ss_s,
  output logic mosi_s
);

  logic [1:0] sclk_m, ss_m, mosi_m;
  logic       sclk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_m <= '0;
      ss_m   <= '0;
      mosi_m <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_m <= {sclk_m[0], sclk};
      ss_m   <= {ss_m[0], ss};
      mosi_m <= {mosi_m[0], mosi};
      sclk_d <= sclk_m[1];
    end
  end

  assign sclk_rise = sclk_m[1] & ~sclk_d;
  assign ss_s      = ss_m[1];
  assign mosi_s    = mosi_m[1];

endmodule

// File: rtl/spi_controller.sv
// SPI-slave command decoder: streams RGB pixels of row-write commands to the
// frame buffer write port and raises a strobe on frame-load commands.
module spi_controller
  import display_pkg::*;
#(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8,
  localparam int nrows   = rows * segments,
  localparam int rw      = (nrows > 1) ? $clog2(nrows) : 1,
  localparam int cw      = (columns > 1) ? $clog2(columns) : 1,
  localparam int pw      = pixel_width(bitwidth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          ss,
  input  logic          mosi,
  output logic          miso,
  output logic [rw-1:0] wrow,
  output logic [cw-1:0] wcol,
  output logic [pw-1:0] wdata,
  output logic          wen,
  input  logic          ready,
  output logic          loaded
);

  localparam logic [cw:0] ncols = columns[cw:0];
  localparam logic [4:0]  nrow5 = nrows[4:0];

  logic                sclk_rise, ss_s, mosi_s;
  dec_state_t          state, state_d;
  logic [6:0]          shreg;
  logic [2:0]          bitcnt;
  logic [1:0]          pixcnt;
  logic [cw:0]         col;
  logic [bitwidth-1:0] ch0, ch1;
  logic [7:0]          byte_in;
  logic                byte_done, col_open, row_ok, pix_done;
  logic                wen_d, loaded_d, row_latch;

  spi_input_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .ss_s      (ss_s),
    .mosi_s    (mosi_s)
  );

  // The byte is assembled combinationally so the completing bit acts in the
  // same cycle it is sampled, keeping the write strobe three clk after sclk.
  assign byte_in   = {shreg, mosi_s};
  assign byte_done = ss_s && sclk_rise && (bitcnt == 3'd7);
  assign col_open  = (col < ncols);
  assign row_ok    = (byte_in[7:4] == CMD_ROW_PREFIX) && ({1'b0, byte_in[3:0]} < nrow5);
  assign pix_done  = (state == ST_ROW) && byte_done && (pixcnt == 2'd2) && col_open;
  assign miso      = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (!ss_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (sclk_rise) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (byte_in == CMD_LOAD) state_d = ST_LOAD;
            else if (row_ok)         state_d = ST_ROW;
            else                     state_d = ST_DISCARD;
          end
        end
        ST_LOAD: state_d = ST_DISCARD;
        default: state_d = state;
      endcase
    end
  end

  always_comb begin
    wen_d     = 1'b0;
    loaded_d  = 1'b0;
    row_latch = 1'b0;
    if (ss_s) begin
      case (state)
        ST_CMD:  row_latch = byte_done && row_ok;
        ST_ROW:  wen_d     = pix_done && ready;
        ST_LOAD: loaded_d  = ready;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg  <= '0;
      bitcnt <= '0;
      pixcnt <= '0;
      col    <= '0;
      ch0    <= '0;
      ch1    <= '0;
      wen    <= 1'b0;
      loaded <= 1'b0;
      wdata  <= '0;
      wrow   <= '0;
      wcol   <= '0;
    end else begin
      wen    <= wen_d;
      loaded <= loaded_d;
      if (!ss_s) begin
        bitcnt <= '0;
        pixcnt <= '0;
        col    <= '0;
      end else begin
        if (sclk_rise) begin
          shreg  <= byte_in[6:0];
          bitcnt <= bitcnt + 3'd1;
        end
        if (row_latch) begin
          wrow   <= rw'(byte_in[3:0]);
          col    <= '0;
          pixcnt <= '0;
        end
        // Dropped pixels (ready low) still consume a column slot.
        if ((state == ST_ROW) && byte_done && col_open) begin
          case (pixcnt)
            2'd0: begin
              ch0    <= bitwidth'(byte_in);
              pixcnt <= 2'd1;
            end
            2'd1: begin
              ch1    <= bitwidth'(byte_in);
              pixcnt <= 2'd2;
            end
            default: begin
              pixcnt <= 2'd0;
              col    <= col + 1'b1;
            end
          endcase
        end
        if (wen_d) begin
          wdata <= {ch0, ch1, bitwidth'(byte_in)};
          wcol  <= col[cw-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Randomized scoreboard bench for spi_controller: a transaction-level model
// queues expected pixel writes and loads; a monitor checks every strobe.
module tb_spi_controller;

  logic        clk = 1'b0, rst = 1'b0, sclk = 1'b0, ss = 1'b0, mosi = 1'b0, ready = 1'b0;
  logic        miso, wen, loaded;
  logic [2:0]  wrow;
  logic [4:0]  wcol;
  logic [23:0] wdata;

  typedef struct {
    int          row;
    int          col;
    logic [23:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         exp_loads = 0;
  logic [7:0] txq[$];
  int         total = 0, bad = 0;

  spi_controller #(.segments(1), .rows(8), .columns(32), .bitwidth(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .sclk   (sclk),
    .ss     (ss),
    .mosi   (mosi),
    .miso   (miso),
    .wrow   (wrow),
    .wcol   (wcol),
    .wdata  (wdata),
    .wen    (wen),
    .ready  (ready),
    .loaded (loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queues.
  always @(negedge clk) begin
    wr_t e;
    if (wen) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_wen got row=%0d col=%0d data=%h want no strobe", wrow, wcol, wdata);
      end else begin
        e = exp_q.pop_front();
        check("wrow", 32'(wrow), 32'(e.row));
        check("wcol", 32'(wcol), 32'(e.col));
        check("wdata", 32'(wdata), 32'(e.data));
      end
    end
    if (loaded) begin
      total++;
      if (exp_loads == 0) begin
        bad++;
        $display("FAIL spurious_loaded got=1 want=0");
      end else begin
        exp_loads--;
      end
    end
  end

  // Reference model: decode a transaction of nbytes complete bytes from txq.
  task automatic model(input int nbytes);
    logic [7:0] cmd;
    wr_t        e;
    if (nbytes == 0) return;
    cmd = txq[0];
    if (cmd == 8'h10) begin
      if (ready) exp_loads++;
    end else if (cmd[7:4] == 4'hF && cmd[3:0] < 4'd8) begin
      for (int k = 0; k < (nbytes - 1) / 3 && k < 32; k++) begin
        if (ready) begin
          e.row  = int'(cmd[3:0]);
          e.col  = k;
          e.data = {txq[1+3*k], txq[2+3*k], txq[3+3*k]};
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic drive_bits(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = txq[i/8][7-(i%8)];
      #20 sclk = 1'b1;
      #20 sclk = 1'b0;
    end
  endtask

  task automatic run(input int nbits, input logic rdy);
    ready = rdy;
    model(nbits / 8);
    ss = 1'b1;
    #40;
    drive_bits(nbits);
    #40 ss = 1'b0;
    #60;
  endtask

  task automatic frame(input logic rdy);
    for (int j = 0; j < 8; j++) begin
      txq.delete();
      txq.push_back(8'hF0 | j[7:0]);
      for (int i = 0; i < 32; i++) begin
        if (j == 0) begin
          txq.push_back(8'hFF);
          txq.push_back(8'hFF);
        end else begin
          txq.push_back(j[7:0]);
          txq.push_back(8'hED);
        end
        txq.push_back(i[7:0]);
      end
      run(8 * 97, rdy);
      check("wen_after_row", 32'(wen), 32'd0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #7;
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_wrow", 32'(wrow), 32'd0);
    check("rst_wcol", 32'(wcol), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    #5 rst = 1'b1;
    #40;

    // Full frame not ready (no writes), then ready (256 writes).
    frame(1'b0);
    frame(1'b1);

    // Load with and without ready.
    txq.delete(); txq.push_back(8'h10);
    run(8, 1'b1);
    check("loaded_after", 32'(loaded), 32'd0);
    run(8, 1'b0);

    // Channel sweep: value in one lane only.
    for (int ch = 0; ch < 3; ch++) begin
      txq.delete(); txq.push_back(8'hF3);
      for (int v = 0; v < 256; v += 17) begin
        for (int l = 0; l < 3; l++) txq.push_back((l == ch) ? v[7:0] : 8'h00);
      end
      run(8 * 49, 1'b1);
    end

    // More than a row's worth of pixels: no wrap.
    txq.delete(); txq.push_back(8'hF5);
    for (int k = 0; k < 34 * 3; k++) txq.push_back(8'($urandom));
    run(8 * 103, 1'b1);

    // Abort after 12 bits, then a normal transaction.
    txq.delete(); txq.push_back(8'hF1); txq.push_back(8'hA5);
    run(12, 1'b1);
    txq.delete(); txq.push_back(8'hF1); txq.push_back(8'h12); txq.push_back(8'h34); txq.push_back(8'h56);
    run(32, 1'b1);

    // Reset mid-pixel: one full pixel, then a partial one.
    txq.delete();
    txq.push_back(8'hF2); txq.push_back(8'h11); txq.push_back(8'h22);
    txq.push_back(8'h33); txq.push_back(8'h44);
    ready = 1'b1;
    model(5);
    ss = 1'b1;
    #40;
    drive_bits(44);
    #40 rst = 1'b0;
    #4;
    check("midrst_wen", 32'(wen), 32'd0);
    check("midrst_loaded", 32'(loaded), 32'd0);
    check("midrst_wdata", 32'(wdata), 32'd0);
    check("midrst_wrow", 32'(wrow), 32'd0);
    check("midrst_wcol", 32'(wcol), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    ss = 1'b0;
    #16 rst = 1'b1;
    #60;

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      int         sel, nb, cut;
      logic [7:0] cmd;
      sel = $urandom_range(0, 9);
      if (sel < 5)      cmd = {4'hF, 4'($urandom_range(0, 15))};
      else if (sel < 7) cmd = 8'h10;
      else              cmd = 8'($urandom);
      txq.delete();
      txq.push_back(cmd);
      nb = $urandom_range(0, 12);
      for (int k = 0; k < nb; k++) txq.push_back(8'($urandom));
      cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run(8 * (nb + 1) - cut, 1'($urandom_range(0, 1)));
    end

    #100;
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("pending_loads", 32'(exp_loads), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
